// File: rtl/ddr2_wr_burst_fifo.sv
// ddr2_wr_burst_fifo: single-clock write-data FIFO with a built-in burst reader for the DDR2 write path.
// Define WR_FIFO_FWFT_EN for first-word-fall-through output; otherwise reads have 1-cycle registered latency.
module ddr2_wr_burst_fifo #(
    parameter int DATA_WIDTH    = 64,
    parameter int ADDR_WIDTH    = 5,
    parameter int WRITE_BURST   = 8,
    parameter int AFULL_THRESH  = (2**ADDR_WIDTH) - 2,
    parameter int AEMPTY_THRESH = 1,
    parameter int PEMPTY_THRESH = WRITE_BURST
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic [DATA_WIDTH-1:0] data_in,
    input  logic                  wr_fifo,
    input  logic                  rd_fifo,
    input  logic                  burst_req,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic                  dout_vd,
    output logic                  burst_busy,
    output logic                  burst_last,
    output logic                  full,
    output logic                  empty,
    output logic                  almost_full,
    output logic                  almost_empty,
    output logic                  prog_empty,
    output logic                  burst_rdy,
    output logic [ADDR_WIDTH:0]   count,
    output logic                  overflow,
    output logic                  underflow
);
    localparam int DEPTH      = 2**ADDR_WIDTH;
    localparam int ONE        = 1;
    localparam int BEAT_MAX_I = WRITE_BURST - 1;

    localparam logic [ADDR_WIDTH:0]   C_DEPTH     = DEPTH[ADDR_WIDTH:0];
    localparam logic [ADDR_WIDTH:0]   C_AFULL     = AFULL_THRESH[ADDR_WIDTH:0];
    localparam logic [ADDR_WIDTH:0]   C_AEMPTY    = AEMPTY_THRESH[ADDR_WIDTH:0];
    localparam logic [ADDR_WIDTH:0]   C_PEMPTY    = PEMPTY_THRESH[ADDR_WIDTH:0];
    localparam logic [ADDR_WIDTH:0]   C_BURST     = WRITE_BURST[ADDR_WIDTH:0];
    localparam logic [ADDR_WIDTH:0]   C_CNT_ONE   = ONE[ADDR_WIDTH:0];
    localparam logic [ADDR_WIDTH-1:0] C_PTR_ONE   = ONE[ADDR_WIDTH-1:0];
    localparam logic [ADDR_WIDTH-1:0] C_BEAT_INIT = BEAT_MAX_I[ADDR_WIDTH-1:0];

    typedef enum logic [1:0] {S_IDLE, S_BURST, S_TAIL} state_t;

    state_t                r_state;
    logic [DATA_WIDTH-1:0] r_mem [DEPTH];
    logic [ADDR_WIDTH-1:0] r_wr_ptr;
    logic [ADDR_WIDTH-1:0] r_rd_ptr;
    logic [ADDR_WIDTH-1:0] r_beat;
    logic [ADDR_WIDTH:0]   r_count;
    logic [DATA_WIDTH-1:0] r_data_out;
    logic                  r_dout_vd;
    logic                  r_busy;
    logic                  r_last;
    logic                  r_ovf;
    logic                  r_unf;

    logic w_full;
    logic w_empty;
    logic w_burst_rdy;
    logic w_rd_req;
    logic w_rd_acc;
    logic w_wr_acc;
    logic w_burst_go;
    logic w_ram_wr;

    assign w_full      = (r_count == C_DEPTH);
    assign w_empty     = (r_count == '0);
    assign w_burst_rdy = (r_count >= C_BURST);

    // In BURST the engine reads every cycle; manual reads are only honoured in IDLE.
    assign w_rd_req   = (r_state == S_BURST) || ((r_state == S_IDLE) && rd_fifo);
    assign w_rd_acc   = w_rd_req && !w_empty;
    assign w_wr_acc   = wr_fifo && (!w_full || w_rd_acc);
    assign w_burst_go = (r_state == S_IDLE) && burst_req && w_burst_rdy;

`ifdef WR_FIFO_FWFT_EN
    logic w_ram_empty;
    logic w_out_load;

    // The output register holds the head word and is part of count, so the RAM holds count - dout_vd.
    assign w_ram_empty = (r_count == {{ADDR_WIDTH{1'b0}}, r_dout_vd});
    assign w_out_load  = !r_dout_vd || w_rd_acc;
    assign w_ram_wr    = w_wr_acc && !(w_out_load && w_ram_empty);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_data_out <= '0;
            r_dout_vd  <= 1'b0;
            r_rd_ptr   <= '0;
        end else if (w_out_load) begin
            if (!w_ram_empty) begin
                r_data_out <= r_mem[r_rd_ptr];
                r_dout_vd  <= 1'b1;
                r_rd_ptr   <= r_rd_ptr + C_PTR_ONE;
            end else if (w_wr_acc) begin
                r_data_out <= data_in;
                r_dout_vd  <= 1'b1;
            end else begin
                r_dout_vd  <= 1'b0;
            end
        end
    end
`else
    assign w_ram_wr = w_wr_acc;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_data_out <= '0;
            r_dout_vd  <= 1'b0;
            r_rd_ptr   <= '0;
        end else begin
            r_dout_vd <= w_rd_acc;
            if (w_rd_acc) begin
                r_data_out <= r_mem[r_rd_ptr];
                r_rd_ptr   <= r_rd_ptr + C_PTR_ONE;
            end
        end
    end
`endif

    always_ff @(posedge clk) begin
        if (w_ram_wr) begin
            r_mem[r_wr_ptr] <= data_in;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_wr_ptr <= '0;
            r_count  <= '0;
            r_ovf    <= 1'b0;
            r_unf    <= 1'b0;
        end else begin
            if (w_ram_wr) begin
                r_wr_ptr <= r_wr_ptr + C_PTR_ONE;
            end
            case ({w_wr_acc, w_rd_acc})
                2'b10:   r_count <= r_count + C_CNT_ONE;
                2'b01:   r_count <= r_count - C_CNT_ONE;
                default: r_count <= r_count;
            endcase
            r_ovf <= wr_fifo && w_full && !w_rd_acc;
            r_unf <= w_rd_req && w_empty;
        end
    end

    // Standard mode needs a TAIL cycle so burst_last/busy line up with the registered last word.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= S_IDLE;
            r_beat  <= '0;
            r_busy  <= 1'b0;
            r_last  <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_burst_go) begin
                        r_state <= S_BURST;
                        r_beat  <= C_BEAT_INIT;
                        r_busy  <= 1'b1;
`ifdef WR_FIFO_FWFT_EN
                        r_last  <= (C_BEAT_INIT == '0);
`endif
                    end
                end
                S_BURST: begin
                    if (r_beat == '0) begin
`ifdef WR_FIFO_FWFT_EN
                        r_state <= S_IDLE;
                        r_busy  <= 1'b0;
                        r_last  <= 1'b0;
`else
                        r_state <= S_TAIL;
                        r_last  <= 1'b1;
`endif
                    end else begin
                        r_beat <= r_beat - C_PTR_ONE;
`ifdef WR_FIFO_FWFT_EN
                        r_last <= (r_beat == C_PTR_ONE);
`endif
                    end
                end
                S_TAIL: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                    r_last  <= 1'b0;
                end
                default: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                    r_last  <= 1'b0;
                end
            endcase
        end
    end

    assign data_out     = r_data_out;
    assign dout_vd      = r_dout_vd;
    assign burst_busy   = r_busy;
    assign burst_last   = r_last;
    assign full         = w_full;
    assign empty        = w_empty;
    assign almost_full  = (r_count >= C_AFULL);
    assign almost_empty = (r_count <= C_AEMPTY);
    assign prog_empty   = (r_count < C_PEMPTY);
    assign burst_rdy    = w_burst_rdy;
    assign count        = r_count;
    assign overflow     = r_ovf;
    assign underflow    = r_unf;

endmodule

// File: tb/tb_ddr2_wr_burst_fifo.sv
// Scoreboard bench for ddr2_wr_burst_fifo (default build, registered-read mode).
`timescale 1ns/1ps
module tb_ddr2_wr_burst_fifo;
    localparam int DW    = 64;
    localparam int AW    = 5;
    localparam int DEPTH = 32;
    localparam int WB    = 8;
    localparam int AF    = 30;
    localparam int AE    = 1;
    localparam int PE    = 8;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic [DW-1:0] data_in = '0;
    logic          wr_fifo = 1'b0;
    logic          rd_fifo = 1'b0;
    logic          burst_req = 1'b0;
    logic [DW-1:0] data_out;
    logic          dout_vd, burst_busy, burst_last, full, empty;
    logic          almost_full, almost_empty, prog_empty, burst_rdy;
    logic [AW:0]   count;
    logic          overflow, underflow;

    ddr2_wr_burst_fifo dut (
        .clk(clk), .reset_n(reset_n), .data_in(data_in), .wr_fifo(wr_fifo),
        .rd_fifo(rd_fifo), .burst_req(burst_req), .data_out(data_out),
        .dout_vd(dout_vd), .burst_busy(burst_busy), .burst_last(burst_last),
        .full(full), .empty(empty), .almost_full(almost_full),
        .almost_empty(almost_empty), .prog_empty(prog_empty),
        .burst_rdy(burst_rdy), .count(count), .overflow(overflow),
        .underflow(underflow)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    // Reference model: stored words, expected output words {last, data}, burst bookkeeping.
    logic [DW-1:0] q[$];
    logic [DW:0]   exp_q[$];
    int            m_left = 0;
    bit            m_tail = 0;
    bit            m_busy = 0;
    bit            e_ovf  = 0;
    bit            e_unf  = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chk_status();
        int n;
        n = q.size();
        chk("count", 64'(count), 64'(n));
        chk("full", full, n == DEPTH);
        chk("empty", empty, n == 0);
        chk("almost_full", almost_full, n >= AF);
        chk("almost_empty", almost_empty, n <= AE);
        chk("prog_empty", prog_empty, n < PE);
        chk("burst_rdy", burst_rdy, n >= WB);
        chk("burst_busy", burst_busy, m_busy);
        chk("overflow", overflow, e_ovf);
        chk("underflow", underflow, e_unf);
    endtask

    // One clock: apply inputs, advance the model by the stated rules, then check status.
    task automatic cycle(input bit wr, input bit rd, input bit breq, input logic [DW-1:0] d);
        int n;
        bit rreq, racc, wacc, last;
        logic [DW-1:0] w;
        data_in = d; wr_fifo = wr; rd_fifo = rd; burst_req = breq;
        n    = q.size();
        rreq = (m_left > 0) ? 1'b1 : (rd && !m_busy);
        racc = rreq && (n > 0);
        wacc = wr && ((n < DEPTH) || racc);
        e_ovf = wr && (n == DEPTH) && !racc;
        e_unf = rreq && (n == 0);
        if (racc) begin
            w    = q.pop_front();
            last = (m_left == 1);
            exp_q.push_back({last, w});
        end
        if (wacc) q.push_back(d);
        if (m_left > 0) begin
            m_left--;
            if (m_left == 0) m_tail = 1;
        end else if (m_tail) begin
            m_tail = 0;
            m_busy = 0;
        end else if (breq && (n >= WB)) begin
            m_left = WB;
            m_busy = 1;
        end
        @(posedge clk);
        @(negedge clk);
        chk_status();
    endtask

    task automatic do_reset();
        #2 reset_n = 1'b0;
        #1;
        chk("rst_data_out", data_out, 64'h0);
        chk("rst_dout_vd", dout_vd, 1'b0);
        chk("rst_burst_busy", burst_busy, 1'b0);
        chk("rst_burst_last", burst_last, 1'b0);
        chk("rst_overflow", overflow, 1'b0);
        chk("rst_underflow", underflow, 1'b0);
        chk("rst_full", full, 1'b0);
        chk("rst_empty", empty, 1'b1);
        chk("rst_almost_empty", almost_empty, 1'b1);
        chk("rst_prog_empty", prog_empty, 1'b1);
        chk("rst_almost_full", almost_full, 1'b0);
        chk("rst_burst_rdy", burst_rdy, 1'b0);
        chk("rst_count", 64'(count), 64'h0);
        q.delete(); exp_q.delete();
        m_left = 0; m_tail = 0; m_busy = 0; e_ovf = 0; e_unf = 0;
        wr_fifo = 1'b0; rd_fifo = 1'b0; burst_req = 1'b0;
        @(posedge clk);
        @(negedge clk);
        reset_n = 1'b1;
    endtask

    task automatic rand_cycles(input int num, input int pw, input int pr, input int pb);
        bit wr, rd, br;
        for (int i = 0; i < num; i++) begin
            wr = ($urandom_range(99) < pw);
            br = ($urandom_range(99) < pb);
            rd = br ? 1'b0 : ($urandom_range(99) < pr);
            cycle(wr, rd, br, {$urandom, $urandom});
        end
    endtask

    // Monitor: every presented word is matched against the scoreboard head.
    initial begin
        logic [DW:0] e;
        forever begin
            @(negedge clk);
            if (reset_n === 1'b1) begin
                if (dout_vd === 1'b1) begin
                    if (exp_q.size() == 0) begin
                        chk("spurious_dout_vd", dout_vd, 1'b0);
                    end else begin
                        e = exp_q.pop_front();
                        chk("data_out", data_out, e[DW-1:0]);
                        chk("burst_last", burst_last, e[DW]);
                    end
                end else begin
                    chk("burst_last_without_vd", burst_last, 1'b0);
                end
            end
        end
    end

    initial begin
        @(negedge clk);
        do_reset();
        cycle(0, 0, 0, '0);

        rand_cycles(60, 70, 20, 15);
        do_reset();
        cycle(0, 0, 0, '0);

        for (int i = 0; i < DEPTH; i++) cycle(1, 0, 0, 64'(i));
        cycle(1, 0, 0, 64'hDEAD_BEEF);
        cycle(0, 0, 0, '0);

        for (int i = 0; i < 10; i++) cycle(1, 1, 0, 64'(100 + i));
        for (int i = 0; i < DEPTH + 2; i++) cycle(0, 1, 0, '0);

        for (int i = 0; i < WB; i++) cycle(1, 0, 0, 64'(i));
        cycle(0, 0, 1, '0);
        cycle(0, 0, 0, '0);
        cycle(0, 1, 1, '0);
        for (int i = 0; i < 10; i++) cycle(0, 0, 0, '0);

        cycle(1, 1, 0, 64'hA5);
        cycle(0, 0, 0, '0);
        cycle(0, 1, 0, '0);
        cycle(0, 0, 0, '0);

        rand_cycles(1500, 70, 20, 12);
        rand_cycles(1500, 40, 30, 12);
        for (int i = 0; i < DEPTH + 12; i++) cycle(0, 1, 0, '0);
        cycle(0, 0, 0, '0);

        chk("pending_reads", 64'(exp_q.size()), 64'h0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

endmodule
